game_controller: RTL and testbench
==================================

# game_controller

Top-level game sequencer for Crossy Robbers. Tracks the round through attract, countdown, play and game-over phases, gating the two player blocks and issuing their reset pulse. Owns both scores in BCD (for the HEX digits) and the round timer, which is clocked off the VGA frame rate. Sits beside vga_controller and color_mapper. Consumes the USB keycode from the SoC and score/hit pulses from the player blocks.

## Interface
- FRAMES_PER_SEC, 60: frame ticks per displayed second.
- ROUND_SECONDS, 60: round length in seconds (1–99).
- WIN_SCORE, 8'h15: BCD score that ends the round early (two BCD digits).
- COUNT_SECONDS, 3: countdown length in seconds (1–3).

Ports:
- Clk  in  1  50 MHz system clock; all state is in this domain.
- Reset  in  1  asynchronous, active-high.
- frame_clk  in  1  VGA_VS (active-low vsync); asynchronous to the block's logic, so it is synchronized internally.
- keycode  in  8  USB HID keycode from the SoC; 8'h00 means no key.
- p1_score_inc, p2_score_inc  in  1  single-Clk pulses; player banked loot.
- p1_hit, p2_hit  in  1  single-Clk pulses; player hit by a car.
- state  out  2  00 ATTRACT, 01 COUNTDOWN, 10 PLAY, 11 GAME_OVER.
- players_enable  out  1  high only in PLAY.
- player_reset  out  1  one-Clk pulse on entry to COUNTDOWN.
- count_left  out  2  countdown seconds remaining (3..1); 0 outside COUNTDOWN.
- time_left  out  7  binary seconds remaining in the round.
- p1_bcd, p2_bcd  out  8  scores as two BCD digits, 00–99.
- winner  out  2  valid in GAME_OVER: 01 P1, 10 P2, 11 tie; 00 in all other states.

## Operation
- frame_clk passes through a 2-flop synchronizer. frame_tick is a one-Clk pulse on the synchronized rising edge (end of vsync pulse).
- enter_press is asserted when keycode==8'h28 and the previous Clk's keycode!=8'h28 (rising-edge detect). esc_press is the same for 8'h29.
- A frame counter counts frame_ticks modulo FRAMES_PER_SEC. It is cleared on every state entry. sec_tick is asserted when a frame_tick wraps the counter.
- ATTRACT: scores are held at 00, time_left at ROUND_SECONDS. enter_press moves to COUNTDOWN.
- COUNTDOWN: count_left loads COUNT_SECONDS on entry and decrements on each sec_tick. A sec_tick while count_left==1 moves to PLAY.
- PLAY: each sec_tick decrements time_left. scoreN_inc adds 1 BCD to that player's score, saturating at 99. hitN subtracts 1 BCD, saturating at 00. If inc and hit arrive in the same Clk for the same player, the score is unchanged. Players are independent.
- PLAY exits to GAME_OVER when time_left==0 or either score >= WIN_SCORE. The check uses registered values, so the exit happens one Clk after the condition first appears.
- GAME_OVER: scores and time_left freeze. winner compares p1_bcd and p2_bcd. enter_press moves to COUNTDOWN with scores cleared and time_left reloaded.
- esc_press in any non-ATTRACT state moves to ATTRACT on the next Clk and clears scores. esc_press has priority over every other transition in the same Clk.
- Score and hit pulses outside PLAY are ignored.
- BCD arithmetic: the low digit wraps 9->0 with a carry; 99 saturates. Decrement borrows 0->9; 00 saturates.

## Timing
- Reset values: state=00, players_enable=0, player_reset=0, count_left=0, time_left=ROUND_SECONDS, p1_bcd=p2_bcd=8'h00, winner=00. The frame counter and all synchronizer and edge-detect flops also reset to 0.
- Reset asserted mid-round returns everything to the reset values immediately, regardless of Clk.
- Keycode to state change: enter_press is combinational from the registered previous keycode, so state updates on the Clk edge after keycode first shows 8'h28.
- frame_clk rising edge to frame_tick: 2–3 Clk.
- Score pulse at Clk N: pN_bcd updates at edge N+1.
- player_reset is high exactly for the first Clk in which state==COUNTDOWN.
- players_enable and count_left are registered with state, with no extra lag.
- A pulse in the same Clk as the PLAY-exit decision is still counted, because state is still PLAY during that Clk.
- A key held across GAME_OVER entry does not restart the round. It must be released and pressed again.

## Test plan
- Reset, then keycode=8'h28 for 2 Clk → state 01, player_reset pulses once. After 3×FRAMES_PER_SEC frame_clk pulses: state 10, players_enable=1, count_left 3→2→1→0.
- In PLAY, issue 12 p1_score_inc pulses → p1_bcd=8'h12. Then 1 p1_hit → 8'h11. Then inc and hit in the same Clk → 8'h11. Then p2_hit at 00 → p2_bcd stays 8'h00.
- Use WIN_SCORE=8'h15 and drive p2 to 15 → state=11 within 2 Clk, winner=10, scores frozen against further pulses.
- Run ROUND_SECONDS×FRAMES_PER_SEC frame ticks with equal scores → time_left=0, state=11, winner=11.
- Hold keycode=8'h28 through GAME_OVER entry → state stays 11. Release to 8'h00, press again → state 01, scores 00, time_left=ROUND_SECONDS.
- Press keycode=8'h29 in COUNTDOWN, in PLAY with scores 07/03, and in GAME_OVER → state 00 next Clk with scores cleared. Assert Reset mid-PLAY → all outputs at reset values asynchronously.

Source files
------------

// File: rtl/game_controller.sv
// Round sequencer for Crossy Robbers: phase FSM, BCD scores, round timer
// and countdown, all paced by frame ticks recovered from VGA vsync.
module game_controller #(
  parameter int unsigned FRAMES_PER_SEC = 60,
  parameter int unsigned ROUND_SECONDS  = 60,
  parameter logic [7:0]  WIN_SCORE      = 8'h15,
  parameter int unsigned COUNT_SECONDS  = 3
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  input  logic       p1_score_inc,
  input  logic       p2_score_inc,
  input  logic       p1_hit,
  input  logic       p2_hit,
  output logic [1:0] state,
  output logic       players_enable,
  output logic       player_reset,
  output logic [1:0] count_left,
  output logic [6:0] time_left,
  output logic [7:0] p1_bcd,
  output logic [7:0] p2_bcd,
  output logic [1:0] winner
);

  localparam int unsigned FCW = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
  localparam logic [FCW-1:0] FRAME_LAST = FCW'(FRAMES_PER_SEC - 1);
  localparam logic [7:0] KEY_ENTER  = 8'h28;
  localparam logic [7:0] KEY_ESC    = 8'h29;
  localparam logic [6:0] ROUND_INIT = 7'(ROUND_SECONDS);
  localparam logic [1:0] COUNT_INIT = 2'(COUNT_SECONDS);

  typedef enum logic [1:0] {
    ST_ATTRACT   = 2'b00,
    ST_COUNTDOWN = 2'b01,
    ST_PLAY      = 2'b10,
    ST_GAME_OVER = 2'b11
  } state_e;

  state_e         state_q, state_d;
  logic           fc_s1, fc_s2, fc_s3;
  logic [7:0]     key_prev;
  logic [FCW-1:0] frame_cnt, frame_d;
  logic           frame_tick, sec_tick, enter_press, esc_press;
  logic           cd_entry;
  logic [1:0]     count_d, winner_d;
  logic [6:0]     time_d;
  logic [7:0]     p1_d, p2_d;
  logic           enable_d, preset_d;

  // BCD increment, saturating at 99
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h99)             r = v;
    else if (v[3:0] == 4'd9)    r = {v[7:4] + 4'd1, 4'd0};
    else                        r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  // BCD decrement, saturating at 00
  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h00)             r = v;
    else if (v[3:0] == 4'd0)    r = {v[7:4] - 4'd1, 4'd9};
    else                        r = {v[7:4], v[3:0] - 4'd1};
    return r;
  endfunction

  // Score update for one player; simultaneous inc and hit cancel
  function automatic logic [7:0] score_next(input logic [7:0] v, input logic inc, input logic hit);
    logic [7:0] r;
    r = v;
    if (inc && !hit)      r = bcd_inc(v);
    else if (hit && !inc) r = bcd_dec(v);
    return r;
  endfunction

  assign frame_tick  = fc_s2 & ~fc_s3;
  assign sec_tick    = frame_tick && (frame_cnt == FRAME_LAST);
  assign enter_press = (keycode == KEY_ENTER) && (key_prev != KEY_ENTER);
  assign esc_press   = (keycode == KEY_ESC) && (key_prev != KEY_ESC);
  assign state       = state_q;

  // vsync synchronizer, edge-detect history and previous keycode
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      fc_s1    <= 1'b0;
      fc_s2    <= 1'b0;
      fc_s3    <= 1'b0;
      key_prev <= 8'h00;
    end else begin
      fc_s1    <= frame_clk;
      fc_s2    <= fc_s1;
      fc_s3    <= fc_s2;
      key_prev <= keycode;
    end
  end

  // Phase state register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= ST_ATTRACT;
    else       state_q <= state_d;
  end

  // Next phase; escape overrides every other transition
  always_comb begin
    state_d = state_q;
    if (esc_press && state_q != ST_ATTRACT) begin
      state_d = ST_ATTRACT;
    end else begin
      case (state_q)
        ST_ATTRACT:   if (enter_press) state_d = ST_COUNTDOWN;
        ST_COUNTDOWN: if (sec_tick && count_left == 2'd1) state_d = ST_PLAY;
        ST_PLAY:      if (time_left == 7'd0 || p1_bcd >= WIN_SCORE || p2_bcd >= WIN_SCORE)
                        state_d = ST_GAME_OVER;
        ST_GAME_OVER: if (enter_press) state_d = ST_COUNTDOWN;
        default:      state_d = ST_ATTRACT;
      endcase
    end
  end

  // Next values for timers, scores and phase-derived outputs
  always_comb begin
    cd_entry = (state_d == ST_COUNTDOWN) && (state_q != ST_COUNTDOWN);
    frame_d  = frame_cnt;
    count_d  = 2'd0;
    time_d   = time_left;
    p1_d     = p1_bcd;
    p2_d     = p2_bcd;
    winner_d = 2'b00;

    if (state_d != state_q)  frame_d = '0;
    else if (sec_tick)       frame_d = '0;
    else if (frame_tick)     frame_d = frame_cnt + FCW'(1);

    if (cd_entry)                       count_d = COUNT_INIT;
    else if (state_d == ST_COUNTDOWN)   count_d = sec_tick ? count_left - 2'd1 : count_left;

    if (state_q == ST_PLAY) begin
      if (sec_tick && time_left != 7'd0) time_d = time_left - 7'd1;
      p1_d = score_next(p1_bcd, p1_score_inc, p1_hit);
      p2_d = score_next(p2_bcd, p2_score_inc, p2_hit);
    end

    // A fresh round or a return to attract starts from a clean slate
    if (cd_entry || state_d == ST_ATTRACT) begin
      time_d = ROUND_INIT;
      p1_d   = 8'h00;
      p2_d   = 8'h00;
    end

    if (state_d == ST_GAME_OVER) begin
      if (p1_d > p2_d)      winner_d = 2'b01;
      else if (p2_d > p1_d) winner_d = 2'b10;
      else                  winner_d = 2'b11;
    end

    enable_d = (state_d == ST_PLAY);
    preset_d = cd_entry;
  end

  // Registered datapath and outputs, updated alongside the phase
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      frame_cnt      <= '0;
      count_left     <= 2'd0;
      time_left      <= ROUND_INIT;
      p1_bcd         <= 8'h00;
      p2_bcd         <= 8'h00;
      winner         <= 2'b00;
      players_enable <= 1'b0;
      player_reset   <= 1'b0;
    end else begin
      frame_cnt      <= frame_d;
      count_left     <= count_d;
      time_left      <= time_d;
      p1_bcd         <= p1_d;
      p2_bcd         <= p2_d;
      winner         <= winner_d;
      players_enable <= enable_d;
      player_reset   <= preset_d;
    end
  end

endmodule

// File: tb/tb_game_controller.sv
// Bench for game_controller: a behavioural round model predicts every
// cycle's outputs into a queue that a negedge monitor drains and compares.
module tb_game_controller;

  localparam int unsigned FPS  = 4;
  localparam int unsigned RSEC = 6;
  localparam logic [7:0]  WIN  = 8'h15;
  localparam int unsigned CSEC = 3;
  localparam int FRAME_PER = 6;
  localparam int S_ATTR = 0, S_CD = 1, S_PLAY = 2, S_GO = 3;

  logic       Clk, Reset, frame_clk;
  logic [7:0] keycode;
  logic       p1_score_inc, p2_score_inc, p1_hit, p2_hit;
  logic [1:0] state, count_left, winner;
  logic       players_enable, player_reset;
  logic [6:0] time_left;
  logic [7:0] p1_bcd, p2_bcd;

  game_controller #(
    .FRAMES_PER_SEC(FPS), .ROUND_SECONDS(RSEC), .WIN_SCORE(WIN), .COUNT_SECONDS(CSEC)
  ) dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .keycode(keycode),
    .p1_score_inc(p1_score_inc), .p2_score_inc(p2_score_inc),
    .p1_hit(p1_hit), .p2_hit(p2_hit),
    .state(state), .players_enable(players_enable), .player_reset(player_reset),
    .count_left(count_left), .time_left(time_left),
    .p1_bcd(p1_bcd), .p2_bcd(p2_bcd), .winner(winner)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    int st; int pe; int pr; int cnt; int tl; int p1; int p2; int win;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   win_dec;

  // Behavioural model state (scores kept as plain decimal)
  int m_state, m_pe, m_pr, m_cnt, m_tl, m_p1, m_p2, m_win, m_frame;
  logic [7:0] m_prev_key;
  bit m_fc_prev, m_pipe0, m_pipe1;
  bit frame_run;
  int fc_ph;

  function automatic logic [7:0] to_bcd(input int n);
    logic [3:0] t, o;
    t = 4'(n / 10);
    o = 4'(n % 10);
    return {t, o};
  endfunction

  function automatic void chk(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, got, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_state = S_ATTR; m_pe = 0; m_pr = 0; m_cnt = 0; m_tl = RSEC;
    m_p1 = 0; m_p2 = 0; m_win = 0; m_frame = 0;
    m_prev_key = 8'h00; m_fc_prev = 0; m_pipe0 = 0; m_pipe1 = 0;
  endfunction

  function automatic int apply_score(input int v, input logic inc, input logic hit);
    if (inc && !hit) return (v >= 99) ? 99 : v + 1;
    if (hit && !inc) return (v <= 0) ? 0 : v - 1;
    return v;
  endfunction

  // Advance the model by one Clk edge using the inputs now being driven
  function automatic void model_step();
    int nst;
    bit enter, esc, tick, sec;
    if (Reset) begin
      model_reset();
      return;
    end
    enter = (keycode == 8'h28) && (m_prev_key != 8'h28);
    esc   = (keycode == 8'h29) && (m_prev_key != 8'h29);
    m_prev_key = keycode;
    // vsync rise seen at this edge acts two edges later
    tick = m_pipe1;
    m_pipe1 = m_pipe0;
    m_pipe0 = frame_clk && !m_fc_prev;
    m_fc_prev = frame_clk;
    sec = tick && (m_frame == int'(FPS) - 1);

    nst = m_state;
    if (esc && m_state != S_ATTR) nst = S_ATTR;
    else begin
      case (m_state)
        S_ATTR: if (enter) nst = S_CD;
        S_CD:   if (sec && m_cnt == 1) nst = S_PLAY;
        S_PLAY: if (m_tl == 0 || m_p1 >= win_dec || m_p2 >= win_dec) nst = S_GO;
        S_GO:   if (enter) nst = S_CD;
        default: nst = S_ATTR;
      endcase
    end

    if (m_state == S_PLAY) begin
      if (sec && m_tl > 0) m_tl = m_tl - 1;
      m_p1 = apply_score(m_p1, p1_score_inc, p1_hit);
      m_p2 = apply_score(m_p2, p2_score_inc, p2_hit);
    end

    m_pr = (nst == S_CD && m_state != S_CD) ? 1 : 0;
    if (m_pr == 1)        m_cnt = CSEC;
    else if (nst != S_CD) m_cnt = 0;
    else if (sec)         m_cnt = m_cnt - 1;

    if (m_pr == 1 || nst == S_ATTR) begin
      m_p1 = 0; m_p2 = 0; m_tl = RSEC;
    end

    if (nst != m_state) m_frame = 0;
    else if (tick)      m_frame = (m_frame + 1) % int'(FPS);

    m_pe = (nst == S_PLAY) ? 1 : 0;
    m_win = 0;
    if (nst == S_GO) m_win = (m_p1 > m_p2) ? 1 : (m_p2 > m_p1) ? 2 : 3;
    m_state = nst;
  endfunction

  function automatic exp_t snap();
    exp_t e;
    e.st = m_state; e.pe = m_pe; e.pr = m_pr; e.cnt = m_cnt;
    e.tl = m_tl; e.p1 = m_p1; e.p2 = m_p2; e.win = m_win;
    return e;
  endfunction

  // Monitor: every negedge compares the DUT against the oldest prediction
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb_state",  int'(state),          e.st);
        chk("sb_enable", int'(players_enable), e.pe);
        chk("sb_preset", int'(player_reset),   e.pr);
        chk("sb_count",  int'(count_left),     e.cnt);
        chk("sb_time",   int'(time_left),      e.tl);
        chk("sb_p1",     int'(p1_bcd),         int'(to_bcd(e.p1)));
        chk("sb_p2",     int'(p2_bcd),         int'(to_bcd(e.p2)));
        chk("sb_winner", int'(winner),         e.win);
      end
    end
  end

  // One Clk: update frame_clk, predict, let the edge happen, queue prediction
  task automatic cycle();
    if (frame_run) begin
      fc_ph = (fc_ph + 1) % FRAME_PER;
      frame_clk = (fc_ph < FRAME_PER / 2);
    end
    model_step();
    @(posedge Clk);
    #1;
    sb.push_back(snap());
  endtask

  task automatic idle(input int n);
    p1_score_inc = 0; p2_score_inc = 0; p1_hit = 0; p2_hit = 0;
    repeat (n) cycle();
  endtask

  task automatic pulse(input logic i1, input logic h1, input logic i2, input logic h2);
    p1_score_inc = i1; p1_hit = h1; p2_score_inc = i2; p2_hit = h2;
    cycle();
    p1_score_inc = 0; p1_hit = 0; p2_score_inc = 0; p2_hit = 0;
  endtask

  task automatic press(input logic [7:0] code);
    keycode = code;
    cycle();
    cycle();
    keycode = 8'h00;
    cycle();
  endtask

  task automatic run_until(input int st, input int limit, input string name);
    int k = 0;
    while (int'(state) != st && k < limit) begin
      cycle();
      k++;
    end
    chk(name, int'(state), st);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_state"},  int'(state), 0);
    chk({tag, "_enable"}, int'(players_enable), 0);
    chk({tag, "_preset"}, int'(player_reset), 0);
    chk({tag, "_count"},  int'(count_left), 0);
    chk({tag, "_time"},   int'(time_left), RSEC);
    chk({tag, "_p1"},     int'(p1_bcd), 0);
    chk({tag, "_p2"},     int'(p2_bcd), 0);
    chk({tag, "_winner"}, int'(winner), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    win_dec = int'(WIN[7:4]) * 10 + int'(WIN[3:0]);
    Reset = 1; keycode = 8'h00; frame_clk = 0; frame_run = 0; fc_ph = 0;
    p1_score_inc = 0; p2_score_inc = 0; p1_hit = 0; p2_hit = 0;
    model_reset();
    repeat (2) @(posedge Clk);
    #1;
    check_reset_values("reset");
    sb.push_back(snap());
    Reset = 0;
    frame_run = 1;
    idle(3);

    // Enter held two Clk: one countdown entry, one player_reset pulse
    keycode = 8'h28;
    cycle();
    chk("enter_state", int'(state), S_CD);
    chk("enter_preset", int'(player_reset), 1);
    chk("enter_count", int'(count_left), CSEC);
    cycle();
    chk("preset_once", int'(player_reset), 0);
    keycode = 8'h00;
    run_until(S_PLAY, 400, "reach_play");
    chk("play_enable", int'(players_enable), 1);
    chk("play_count", int'(count_left), 0);

    // Scoring: carry, hit, cancel, floor
    for (int i = 0; i < 12; i++) begin pulse(1, 0, 0, 0); idle(1); end
    chk("p1_twelve", int'(p1_bcd), 8'h12);
    pulse(0, 1, 0, 0);
    chk("p1_hit", int'(p1_bcd), 8'h11);
    pulse(1, 1, 0, 0);
    chk("p1_cancel", int'(p1_bcd), 8'h11);
    pulse(0, 0, 0, 1);
    chk("p2_floor", int'(p2_bcd), 8'h00);

    // P2 reaches the win score: early game over, then frozen
    for (int i = 0; i < 15; i++) begin pulse(0, 0, 1, 0); idle(1); end
    chk("win_state", int'(state), S_GO);
    chk("win_winner", int'(winner), 2);
    for (int i = 0; i < 3; i++) pulse(1, 0, 1, 0);
    chk("frozen_p1", int'(p1_bcd), 8'h11);
    chk("frozen_p2", int'(p2_bcd), 8'h15);

    // Full-length round with enter held throughout: timeout tie
    keycode = 8'h28;
    cycle();
    chk("restart_state", int'(state), S_CD);
    run_until(S_GO, 600, "timeout_go");
    chk("timeout_time", int'(time_left), 0);
    chk("timeout_winner", int'(winner), 3);
    idle(5);
    chk("held_key_stays", int'(state), S_GO);
    keycode = 8'h00;
    cycle();
    keycode = 8'h28;
    cycle();
    chk("repress_state", int'(state), S_CD);
    chk("repress_time", int'(time_left), RSEC);
    chk("repress_p1", int'(p1_bcd), 0);
    keycode = 8'h00;
    cycle();

    // Escape from countdown, from play at 07/03, from game over
    keycode = 8'h29;
    cycle();
    chk("esc_cd", int'(state), S_ATTR);
    keycode = 8'h00;
    cycle();
    press(8'h28);
    run_until(S_PLAY, 400, "reach_play2");
    for (int i = 0; i < 10; i++) begin pulse(1, 0, 0, 0); idle(1); end
    for (int i = 0; i < 3; i++)  begin pulse(0, 1, 0, 0); idle(1); end
    for (int i = 0; i < 3; i++)  begin pulse(0, 0, 1, 0); idle(1); end
    chk("pre_esc_p1", int'(p1_bcd), 8'h07);
    chk("pre_esc_p2", int'(p2_bcd), 8'h03);
    keycode = 8'h29;
    cycle();
    chk("esc_play", int'(state), S_ATTR);
    chk("esc_play_p1", int'(p1_bcd), 0);
    chk("esc_play_p2", int'(p2_bcd), 0);
    chk("esc_play_time", int'(time_left), RSEC);
    keycode = 8'h00;
    cycle();
    press(8'h28);
    run_until(S_GO, 600, "reach_go");
    keycode = 8'h29;
    cycle();
    chk("esc_go", int'(state), S_ATTR);
    keycode = 8'h00;
    cycle();

    // Randomized soak
    for (int i = 0; i < 2500; i++) begin
      int r;
      r = int'($urandom_range(0, 199));
      if (r < 5)       keycode = 8'h28;
      else if (r == 5) keycode = 8'h29;
      else if (r < 12) keycode = 8'h04;
      else             keycode = 8'h00;
      p1_score_inc = ($urandom_range(0, 3) == 0);
      p1_hit       = ($urandom_range(0, 5) == 0);
      p2_score_inc = ($urandom_range(0, 3) == 0);
      p2_hit       = ($urandom_range(0, 5) == 0);
      cycle();
    end
    keycode = 8'h00;
    idle(2);

    // Asynchronous reset in the middle of play
    if (int'(state) != S_PLAY) begin
      press(8'h28);
      run_until(S_PLAY, 400, "reach_play3");
    end
    for (int i = 0; i < 4; i++) pulse(1, 0, 1, 0);
    Reset = 1;
    #1;
    check_reset_values("async");
    sb.delete();
    model_reset();
    sb.push_back(snap());
    cycle();
    cycle();
    Reset = 0;
    idle(10);
    press(8'h28);
    idle(20);

    repeat (3) @(negedge Clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
